// File: rtl/aa_frame_ctrl.sv
// Anti-aliasing frame sequencer: raster-scans a frame buffer, fetches 4-connected
// neighbours, and writes a blended or pass-through pixel over a ready/valid port.
module aa_frame_ctrl #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PIX_W-1:0]  th,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    input  logic              wr_ready
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam int COL_W = $clog2(WIDTH);
    localparam int SUM_W = PIX_W + 3;

    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EVAL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]        fcnt;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] pix_addr;
    logic [PIX_W-1:0]  th_q;
    logic [PIX_W-1:0]  c_q;
    logic [PIX_W-1:0]  u_q;
    logic [PIX_W-1:0]  d_q;
    logic [PIX_W-1:0]  l_q;
    logic [PIX_W-1:0]  r_q;

    logic              accept_start;
    logic              interior;
    logic              fetch_last;
    logic              last_pix;
    logic              is_edge;
    logic [SUM_W-1:0]  sum;
    logic [PIX_W-1:0]  avg;

    assign interior   = (row != '0) && (row != ROW_LAST) &&
                        (col != '0) && (col != COL_LAST);
    assign fetch_last = interior ? (fcnt == 3'd5) : (fcnt == 3'd1);
    assign last_pix   = (row == ROW_LAST) && (col == COL_LAST);

    assign is_edge = interior && (c_q > th_q) &&
                     ((u_q < th_q) || (d_q < th_q) || (l_q < th_q) || (r_q < th_q));

    // Centre weighted 4x against the four neighbours, total weight 8.
    assign sum = {1'b0, c_q, 2'b00} + SUM_W'(u_q) + SUM_W'(d_q)
               + SUM_W'(l_q) + SUM_W'(r_q);
    assign avg = PIX_W'(sum >> 3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        accept_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    accept_start = 1'b1;
                    state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                busy  = 1'b1;
                rd_en = interior ? (fcnt <= 3'd4) : (fcnt == 3'd0);
                if (fetch_last) begin
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                busy      = 1'b1;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (wr_ready) begin
                    state_nxt = last_pix ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    // Issue order within a fetch: centre, up, down, left, right.
    always_comb begin
        rd_addr = '0;
        if (rd_en) begin
            case (fcnt)
                3'd0:    rd_addr = pix_addr;
                3'd1:    rd_addr = pix_addr - ROW_STEP;
                3'd2:    rd_addr = pix_addr + ROW_STEP;
                3'd3:    rd_addr = pix_addr - ONE_A;
                3'd4:    rd_addr = pix_addr + ONE_A;
                default: rd_addr = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt     <= '0;
            row      <= '0;
            col      <= '0;
            pix_addr <= '0;
            th_q     <= '0;
            c_q      <= '0;
            u_q      <= '0;
            d_q      <= '0;
            l_q      <= '0;
            r_q      <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            if (accept_start) begin
                th_q     <= th;
                row      <= '0;
                col      <= '0;
                pix_addr <= '0;
            end

            // Read data lags its issue by one cycle, so slot n lands when fcnt == n+1.
            if (state == S_FETCH) begin
                fcnt <= fetch_last ? 3'd0 : fcnt + 3'd1;
                case (fcnt)
                    3'd1:    c_q <= rd_data;
                    3'd2:    u_q <= rd_data;
                    3'd3:    d_q <= rd_data;
                    3'd4:    l_q <= rd_data;
                    3'd5:    r_q <= rd_data;
                    default: ;
                endcase
            end else begin
                fcnt <= '0;
            end

            if (state == S_EVAL) begin
                wr_addr <= pix_addr;
                wr_data <= is_edge ? avg : c_q;
            end

            if ((state == S_WRITE) && wr_ready) begin
                pix_addr <= pix_addr + ONE_A;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_aa_frame_ctrl.sv
// Scoreboard bench for aa_frame_ctrl on a 4x4 frame with hand-computed pixels.
module tb_aa_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [PW-1:0] th;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          wr_ready;

    aa_frame_ctrl #(
        .WIDTH (W),
        .HEIGHT(H),
        .PIX_W (PW),
        .ADDR_W(AW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .th      (th),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem [16];
    int          frm1 [16];
    int          frm2 [16];
    int          exp1 [16];
    int          exp2 [16];
    int          rd_exp [32];

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int start_cyc, done_cyc, done_cnt;
    int rd_cnt, rd_at_hs0, hs_cnt, overlap;
    int hold_cnt, hold_chg, hold_data;
    int hs_cyc [16];
    int rd_log[$];
    bit stall_en = 1'b0;
    int stall_cnt;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr[3:0]];
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    // Output buffer: ready except for three stalled cycles on pixel 6 when enabled.
    initial begin
        wr_ready  = 1'b1;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!stall_en) stall_cnt = 0;
            if (stall_en && wr_en && (wr_addr == 8'd6) && (stall_cnt < 3)) begin
                wr_ready = 1'b0;
                stall_cnt++;
            end else begin
                wr_ready = 1'b1;
            end
        end
    end

    // Monitor: samples after the drivers settle, pops the scoreboard on every handshake.
    always @(negedge clk) begin
        exp_t e;
        #2;
        cyc++;
        if (reset_n) begin
            if (start && !busy && !done && !abort) start_cyc = cyc;
            if (rd_en) begin
                rd_cnt++;
                rd_log.push_back(int'(rd_addr));
            end
            if (rd_en && wr_en) overlap++;
            if (wr_en && (wr_addr == 8'd6)) begin
                if (hold_cnt == 0) hold_data = int'(wr_data);
                else if (int'(wr_data) != hold_data) hold_chg++;
                hold_cnt++;
            end
            if (wr_en && wr_ready) begin
                if (hs_cnt == 0) rd_at_hs0 = rd_cnt;
                if (hs_cnt < 16) hs_cyc[hs_cnt] = cyc;
                hs_cnt++;
                check("sb_has_entry", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("wr_addr", int'(wr_addr), e.addr);
                    check("wr_data", int'(wr_data), e.data);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", int'(busy), 0);
            end
        end
    end

    task automatic load(input int sel);
        for (int i = 0; i < 16; i++) mem[i] = 8'((sel == 1) ? frm1[i] : frm2[i]);
    endtask

    task automatic push_exp(input int sel, input int n);
        for (int i = 0; i < n; i++) sb.push_back('{addr: i, data: (sel == 1) ? exp1[i] : exp2[i]});
    endtask

    task automatic clear_logs();
        rd_cnt = 0; rd_at_hs0 = 0; hs_cnt = 0; overlap = 0; done_cnt = 0;
        hold_cnt = 0; hold_chg = 0; hold_data = 0; start_cyc = 0; done_cyc = 0;
        rd_log.delete();
        for (int i = 0; i < 16; i++) hs_cyc[i] = 0;
    endtask

    task automatic do_start(input int t);
        th    = 8'(t);
        start = 1'b1;
        sync();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke_busy, input bit poke_done);
        bit seen  = 1'b0;
        bit poked = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            sync();
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                if (poke_done) start = 1'b1;
            end else if (poke_busy && !poked && hs_cnt == 2) begin
                start = 1'b1;
                th    = 8'd0;
                poked = 1'b1;
            end
        end
        check("done_seen", int'(seen), 1);
        sync();
        start = 1'b0;
        check("done_one_cycle", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        sync();
        check("still_idle", int'(busy), 0);
    endtask

    initial begin
        int bad;
        bit found;

        frm1 = '{255, 10, 20, 30,  200, 200, 200, 200,  40, 200, 100, 60,  5, 6, 7, 8};
        exp1 = '{255, 10, 20, 30,  200, 176, 165, 200,  40, 143, 100, 60,  5, 6, 7, 8};
        frm2 = '{1, 200, 0, 3,  200, 200, 100, 200,  4, 200, 200, 5,  6, 7, 8, 9};
        exp2 = '{1, 200, 0, 3,  200, 200, 100, 200,  4, 151, 139, 5,  6, 7, 8, 9};
        rd_exp = '{0, 1, 2, 3, 4,  5, 1, 9, 4, 6,  6, 2, 10, 5, 7,  7, 8,
                   9, 5, 13, 8, 10,  10, 6, 14, 9, 11,  11, 12, 13, 14, 15};

        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        th      = '0;
        clear_logs();
        load(1);
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", int'({busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data}), 0);
        reset_n = 1'b1;
        sync();

        // Full frame, ready always high, with a stray start mid-frame.
        clear_logs();
        push_exp(1, 16);
        do_start(100);
        wait_done(1'b1, 1'b0);
        check("writes_total", hs_cnt, 16);
        check("reads_total", rd_cnt, 32);
        bad = 0;
        if (rd_log.size() != 32) bad = 99;
        else for (int i = 0; i < 32; i++) if (rd_log[i] != rd_exp[i]) bad++;
        check("rd_addr_seq_errors", bad, 0);
        check("rd_wr_overlap", overlap, 0);
        check("done_pulses", done_cnt, 1);
        check("border_reads_px0", rd_at_hs0, 1);
        check("border_latency", hs_cyc[0] - start_cyc, 4);
        check("interior_latency", hs_cyc[5] - hs_cyc[4], 8);
        check("start_to_done", done_cyc - start_cyc, 81);
        check("last_hs_to_done", done_cyc - hs_cyc[15], 1);
        check("sb_drained", sb.size(), 0);

        // Three-cycle stall on pixel 6.
        clear_logs();
        stall_en = 1'b1;
        push_exp(1, 16);
        do_start(100);
        wait_done(1'b0, 1'b0);
        stall_en = 1'b0;
        check("stall_hold_cycles", hold_cnt, 4);
        check("stall_data_changes", hold_chg, 0);
        check("stall_px6_span", hs_cyc[6] - hs_cyc[5], 11);
        check("post_stall_fetch", hs_cyc[7] - hs_cyc[6], 4);
        check("stall_start_to_done", done_cyc - start_cyc, 84);
        check("sb_drained_stall", sb.size(), 0);

        // Abort on the first fetch cycle of pixel 9.
        clear_logs();
        push_exp(1, 9);
        do_start(100);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (hs_cnt == 9 && rd_en && rd_addr == 8'd9) found = 1'b1;
            else sync();
        end
        check("abort_point_reached", int'(found), 1);
        abort = 1'b1;
        sync();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_rd_en", int'(rd_en), 0);
        check("abort_wr_en", int'(wr_en), 0);
        repeat (10) sync();
        check("abort_no_done", done_cnt, 0);
        check("abort_writes", hs_cnt, 9);
        check("sb_drained_abort", sb.size(), 0);

        // Rescan after abort starts again from address 0.
        clear_logs();
        push_exp(1, 16);
        do_start(100);
        wait_done(1'b0, 1'b0);
        check("rescan_writes", hs_cnt, 16);
        check("rescan_start_to_done", done_cyc - start_cyc, 81);
        check("sb_drained_rescan", sb.size(), 0);

        // Reset during the write of pixel 3.
        clear_logs();
        push_exp(1, 4);
        do_start(100);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (wr_en && wr_addr == 8'd3) found = 1'b1;
            else sync();
        end
        check("reset_point_reached", int'(found), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", int'({busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data}), 0);
        sync();
        reset_n = 1'b1;
        repeat (3) sync();
        check("midreset_no_done", done_cnt, 0);
        check("midreset_idle", int'(busy), 0);
        check("sb_drained_reset", sb.size(), 0);

        // Second frame: equality is not an edge; start during DONE is ignored.
        load(2);
        clear_logs();
        push_exp(2, 16);
        do_start(100);
        wait_done(1'b0, 1'b1);
        check("frame2_writes", hs_cnt, 16);
        check("frame2_done_pulses", done_cnt, 1);
        check("sb_drained_frame2", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aa_frame_ctrl.md
Name: aa_frame_ctrl

Overview:
Frame-level sequencer for the anti-aliasing filter. On `start` it raster-scans a WIDTH x HEIGHT single-channel frame held in a synchronous-read frame buffer and fetches each pixel's 4-connected neighbours. It evaluates the edge condition against a threshold and writes either a blended or an unmodified pixel to an output buffer through a ready/valid write port. It sits between the frame buffer and the post-AA display buffer and reports `busy`/`done` to the frame scheduler.

Parameters:
- WIDTH, 64, pixels per row (>=3)
- HEIGHT, 64, rows per frame (>=3)
- PIX_W, 8, bits per pixel
- ADDR_W, 12, address width; WIDTH*HEIGHT <= 2^ADDR_W

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin frame scan; sampled in IDLE only
- abort  in  1  terminate scan; return to IDLE next cycle
- th  in  PIX_W  edge threshold; latched on accepted start
- busy  out  1  high from accepted start until done or abort
- done  out  1  one-cycle pulse after last pixel written
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  ADDR_W  read address = row*WIDTH+col
- rd_data  in  PIX_W  read data, valid exactly 1 cycle after rd_en
- wr_en  out  1  output write valid
- wr_addr  out  ADDR_W  output address = row*WIDTH+col
- wr_data  out  PIX_W  output pixel
- wr_ready  in  1  output buffer accepts when wr_en&&wr_ready

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state IDLE; row=col=0; latched th=0. Reset mid-frame aborts silently with no done pulse.
- States: IDLE, FETCH, EVAL, WRITE, DONE.
- IDLE: start=1 latches th, row=col=0, busy<=1, goes to FETCH. start while busy is ignored.
- FETCH, interior pixel (0<row<HEIGHT-1, 0<col<WIDTH-1):
  - rd_en high for 5 consecutive cycles, addresses in order C, U(row-1), D(row+1), L(col-1), R(col+1).
  - Each rd_data is captured into its register the cycle after its issue.
  - State moves to EVAL the cycle after R's data is captured.
- FETCH, border pixel: single read of C only, then EVAL.
- EVAL (1 cycle):
  - edge = interior && (C > th) && (U<th || D<th || L<th || R<th). Comparisons are strict unsigned; equality never counts as edge.
  - edge: wr_data = (4*C + U + D + L + R) >> 3, computed in PIX_W+3 bits, truncated to PIX_W. The result cannot exceed 2^PIX_W-1.
  - otherwise: wr_data = C.
  - wr_addr = row*WIDTH+col; next state WRITE.
- WRITE:
  - wr_en=1; wr_addr/wr_data held stable until wr_ready=1.
  - On handshake, wr_en drops next cycle and col/row advance: col wraps to 0 at WIDTH-1 and row increments.
  - Last pixel (HEIGHT-1, WIDTH-1) goes to DONE; otherwise to FETCH.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start in the DONE cycle is ignored.
- rd_en is never high in EVAL/WRITE. wr_en is never high outside WRITE.
- Minimum per-pixel latency, start of FETCH to handshake cycle:
  - interior: 8 cycles (5 issue + 1 last data + 1 EVAL + 1 WRITE)
  - border: 4 cycles
- abort:
  - Any state except IDLE: next cycle state=IDLE, busy=0, rd_en=wr_en=0, no done pulse.
  - A write handshaking in the same cycle as abort counts as completed.
  - abort has priority over start.
- Data captured in FETCH is never reused across pixels; every pixel is refetched.

Test Plan:
1. WIDTH=HEIGHT=4, th=100, interior (1,1) C=200, U=10, D=L=R=200 -> wr_addr=5, wr_data=(800+610)>>3=176.
2. Same frame, all 5 samples at (1,1) = 200 -> not edge, wr_data=200. Set C=100 (=th) with U=0 -> not edge, wr_data=100.
3. Border pixel (0,0)=255, (0,1)=0, th=100 -> exactly one rd_en (addr 0), wr_data=255; pixel latency 4 cycles with wr_ready tied high.
4. Full 4x4 frame, wr_ready=1:
   - exactly 32 rd_en cycles (4 interior x5 + 12 border) and 16 writes at addresses 0..15 in order;
   - done pulses once, 1 cycle after the addr-15 handshake;
   - busy falls with done; total 4*8+12*4+1 = 81 cycles start-accept to done.
5. wr_ready held low 3 cycles during pixel 6 -> wr_en, wr_addr=6, wr_data constant for 4 cycles; next FETCH starts the cycle after the handshake.
6. abort asserted during FETCH of pixel 9 -> next cycle busy=0, rd_en=0, no done. A new start rescans from addr 0. Repeat with reset_n pulsed low mid-WRITE -> all outputs 0 immediately.
